// File: rtl/modred_arbiter.sv
// ---------------------------------------------------------------------------
// modred_arbiter
//
// Shares one modulo-65537 reduction datapath among NREQ requesters. A
// round-robin arbiter picks one requester per cycle. Its signed 2*WIDTH-bit
// operand is registered into stage 1. The reduced residue is registered into
// stage 2, which drives the output directly.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand-present flags            [NREQ]
//   req_data   packed signed operands, i at [i*2W +: 2W]      [NREQ*2*WIDTH]
//   req_ready  one-hot (or zero) accept strobe                [NREQ]
//   out_valid  result present
//   out_data   residue in 0..65536                            [WIDTH]
//   out_id     index of the requester that issued the result  [IDW]
//   out_ready  downstream accepts the result
//   busy       at least one pipeline stage holds valid data
// ---------------------------------------------------------------------------
module modred_arbiter #(
    parameter int WIDTH = 18,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*2*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDW-1:0]          out_id,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int OPW  = 2 * WIDTH;
    // The operand is sign-extended to a multiple of 32 bits. Because
    // 2^32 == 1 (mod 65537), the weight of the extended sign bit then
    // folds to a plain -1.
    localparam int XW   = ((OPW + 31) / 32) * 32;
    localparam int NC   = XW / 16;
    localparam int ACCW = 16 + $clog2(NC) + 3;
    localparam logic signed [ACCW-1:0] MODULUS = ACCW'(65537);

    // Combinational reducer. Because 2^16 == -1 (mod 65537), the operand
    // folds to an alternating sum of its 16-bit digits. That sum stays within
    // a few multiples of the modulus, so a short chain of conditional
    // corrections brings it into 0..65536.
    function automatic logic [WIDTH-1:0] modulo(input logic [OPW-1:0] x);
        logic [XW-1:0]          xe;
        logic signed [ACCW-1:0] acc;
        logic signed [ACCW-1:0] chunk;
        xe            = {XW{x[OPW-1]}};
        xe[OPW-1:0]   = x;
        acc           = '0;
        if (xe[XW-1]) begin
            acc = '1;
        end
        for (int k = 0; k < NC; k++) begin
            chunk       = '0;
            chunk[15:0] = xe[k*16 +: 16];
            if (k % 2 == 0) begin
                acc = acc + chunk;
            end else begin
                acc = acc - chunk;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (acc[ACCW-1]) begin
                acc = acc + MODULUS;
            end else if (acc >= MODULUS) begin
                acc = acc - MODULUS;
            end
        end
        return WIDTH'(unsigned'(acc));
    endfunction

    logic [OPW-1:0]   req_op [NREQ];

    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   s1_data_q,  s1_data_d;
    logic [IDW-1:0]   s1_id_q,    s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [IDW-1:0]   s2_id_q,    s2_id_d;
    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;

    logic             s2_adv, s1_adv, accept;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   rr_next;

    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = s1_valid_q && s2_adv;
    assign accept = !s1_valid_q || s2_adv;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_op[gi]    = req_data[gi*OPW +: OPW];
            assign req_ready[gi] = !rst && accept && grant_found &&
                                   (grant_id == IDW'(gi));
        end
    endgenerate

    // Priority scan starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin : arb_scan
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign rr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        rr_ptr_d   = rr_ptr_q;

        // accept already implies stage 1 is empty or moving on, so an idle
        // accept simply empties it.
        if (accept) begin
            if (grant_found) begin
                s1_valid_d = 1'b1;
                s1_data_d  = req_op[grant_id];
                s1_id_d    = grant_id;
                rr_ptr_d   = rr_next;
            end else begin
                s1_valid_d = 1'b0;
            end
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = modulo(s1_data_q);
            s2_id_d    = s1_id_q;
        end else if (out_ready && s2_valid_q) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_modred_arbiter.sv
// ---------------------------------------------------------------------------
// tb_modred_arbiter
//
// Directed bench for modred_arbiter. Inputs change 1 time unit after each
// rising edge. Outputs are sampled a further time unit later.
// ---------------------------------------------------------------------------
module tb_modred_arbiter;

    localparam int WIDTH = 18;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int OPW   = 2 * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*OPW-1:0]   req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    modred_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [OPW-1:0] v);
        req_data[i*OPW +: OPW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1; req_data = '0;
        tick(); tick(); #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 18'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0; req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        set_op(0, 36'd65540); req_valid = 4'b0001; out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000; #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 0000", req_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_s1: got %b expected 1", busy); end
        tick();
        $display("txn single: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 18'd3) begin n_fail++; $display("FAIL single_data: got %0d expected 3", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", out_id); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_drain_busy: got %b expected 0", busy); end
    endtask

    // Back-to-back residues on requester 2 (rr_ptr is 1, only 2 requests).
    task automatic test_sweep();
        logic [OPW-1:0] ops [5];
        int             expv [5];
        ops  = '{36'd0, 36'd65537, -36'sd1, -36'sd48577, 36'd123085};
        expv = '{0, 0, 65536, 16960, 57548};
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n < 5) begin
                set_op(2, ops[n]); req_valid = 4'b0100;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (n < 5) begin
                n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL sweep_grant[%0d]: got %b expected 0100", n, req_ready); end
            end
            if (n >= 2 && n < 7) begin
                $display("txn sweep: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d]: got %b expected 1", n-2, out_valid); end
                n_checks++; if (out_data !== WIDTH'(expv[n-2])) begin n_fail++; $display("FAIL sweep_data[%0d]: got %0d expected %0d", n-2, out_data, expv[n-2]); end
                n_checks++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL sweep_id[%0d]: got %0d expected 2", n-2, out_id); end
            end
            if (n == 7) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_idle_busy: got %b expected 0", busy); end
            end
            tick();
        end
    endtask

    // Extreme operands on requester 3: range edges and 2^35 folding.
    task automatic test_extremes();
        logic [OPW-1:0] ops [5];
        int             expv [5];
        ops  = '{36'd65536, 36'h7_FFFF_FFFF, 36'h8_0000_0000, 36'd131074, -36'sd65537};
        expv = '{65536, 7, 65529, 0, 0};
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            if (n < 5) begin
                set_op(3, ops[n]); req_valid = 4'b1000;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (n >= 2) begin
                $display("txn extreme: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
                n_checks++; if (out_data !== WIDTH'(expv[n-2]) || out_valid !== 1'b1) begin n_fail++; $display("FAIL extreme_data[%0d]: got %0d (valid %b) expected %0d", n-2, out_data, out_valid, expv[n-2]); end
                n_checks++; if (out_id !== 2'd3) begin n_fail++; $display("FAIL extreme_id[%0d]: got %0d expected 3", n-2, out_id); end
            end
            tick();
        end
    endtask

    // All four requesting: strict rotation 0,1,2,3,... one grant per cycle.
    task automatic test_fairness();
        int             w;
        logic [NREQ-1:0] er;
        out_ready = 1'b1;
        for (int n = 0; n < 13; n++) begin
            if (n < 10) begin
                for (int i = 0; i < NREQ; i++) set_op(i, OPW'(1000 + 4*n + i));
                req_valid = 4'b1111;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            er = (n < 10) ? (4'b0001 << (n % 4)) : 4'b0000;
            n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b expected %b", n, req_ready, er); end
            if (n >= 2 && n < 12) begin
                w = (n - 2) % 4;
                $display("txn fair: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
                n_checks++; if (out_valid !== 1'b1 || out_id !== IDW'(w)) begin n_fail++; $display("FAIL fair_id[%0d]: got %0d (valid %b) expected %0d", n-2, out_id, out_valid, w); end
                n_checks++; if (out_data !== WIDTH'(1000 + 4*(n-2) + w)) begin n_fail++; $display("FAIL fair_data[%0d]: got %0d expected %0d", n-2, out_data, 1000 + 4*(n-2) + w); end
            end
            if (n == 12) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got %b expected 0", out_valid); end
            end
            tick();
        end
    endtask

    // Requesters 1 and 3 with a 5-cycle output stall (rr_ptr starts at 2).
    task automatic test_backpressure();
        logic [NREQ-1:0] er [13];
        logic            ev [13];
        int              eid [13];
        int              accepts;
        int              ed;
        er  = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eid = '{0, 0, 3, 3, 3, 3, 3, 3, 1, 3, 1, 3, 0};
        accepts = 0;
        set_op(1, 36'd70000);
        set_op(3, 36'd200000);
        for (int n = 0; n < 13; n++) begin
            req_valid = (n <= 9) ? 4'b1010 : 4'b0000;
            out_ready = (n >= 7);
            #1;
            n_checks++; if (req_ready !== er[n]) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b expected %b", n, req_ready, er[n]); end
            n_checks++; if (out_valid !== ev[n]) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected %b", n, out_valid, ev[n]); end
            if (ev[n]) begin
                ed = (eid[n] == 3) ? 3389 : 4463;
                $display("txn bp: id=%0d data=%0d ready=%b", out_id, out_data, out_ready);
                n_checks++; if (out_id !== IDW'(eid[n]) || out_data !== WIDTH'(ed)) begin n_fail++; $display("FAIL bp_result[%0d]: got id %0d data %0d expected id %0d data %0d", n, out_id, out_data, eid[n], ed); end
            end
            if (n <= 6 && req_ready != 4'b0000) accepts++;
            if (n == 6) begin
                n_checks++; if (accepts != 2) begin n_fail++; $display("FAIL bp_accepts_before_stall: got %0d expected 2", accepts); end
            end
            tick();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_final_busy: got %b expected 0", busy); end
    endtask

    // Two operands in flight, one-edge reset; rr_ptr would otherwise be 2.
    task automatic test_reset_midflight();
        set_op(0, 36'd5); set_op(1, 36'd6);
        req_valid = 4'b0011; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b1; out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready2: got %b expected 0000", req_ready); end
        rst = 1'b0; req_valid = 4'b1111; set_op(0, 36'd7); #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000; #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_result: got valid %b id %0d data %0d expected none", out_valid, out_id, out_data); end
        tick();
        $display("txn mid: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 18'd7 || out_id !== 2'd0) begin n_fail++; $display("FAIL mid_result: got valid %b id %0d data %0d expected 1/0/7", out_valid, out_id, out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got valid %b busy %b expected 0/0", out_valid, busy); end
    endtask

    // Pulses on requester 3 every third cycle, then a probe that rr wrapped to 0.
    task automatic test_sparse();
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            set_op(3, OPW'(300 + p)); req_valid = 4'b1000; #1;
            n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_grant[%0d]: got %b expected 1000", p, req_ready); end
            tick();
            req_valid = 4'b0000; #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_early[%0d]: got %b expected 0", p, out_valid); end
            tick();
            $display("txn sparse: id=%0d data=%0d valid=%b", out_id, out_data, out_valid);
            n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== WIDTH'(300 + p)) begin n_fail++; $display("FAIL sparse_result[%0d]: got valid %b id %0d data %0d expected 1/3/%0d", p, out_valid, out_id, out_data, 300 + p); end
            tick();
        end
        set_op(1, 36'd11); req_valid = 4'b1010; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_rr_wrap: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 18'd11) begin n_fail++; $display("FAIL sparse_probe: got valid %b id %0d data %0d expected 1/1/11", out_valid, out_id, out_data); end
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_sweep();
        test_extremes();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_sparse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modred_arbiter.md
Name: modred_arbiter

Overview:
- Shares one modulo-65537 reduction datapath among NREQ requesters, typically NTT butterfly units producing 2*WIDTH-bit signed products.
- Selects requesters round-robin and feeds the winner into a 2-stage registered pipeline around the combinational `modulo` reducer.
- Returns each residue in [0, 65536] tagged with the requester's ID, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 18, residue width; each operand is 2*WIDTH bits, signed two's complement.
- NREQ, 4, number of requesters; must be ≥2.
- IDW, 2, ID tag width; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  bit i set: requester i presents an operand.
- req_data  input  NREQ*2*WIDTH  packed signed operands; requester i occupies bits [i*2*WIDTH +: 2*WIDTH].
- req_ready  output  NREQ  one-hot or zero; bit i set: requester i's operand is accepted this cycle.
- out_valid  output  1  result present.
- out_data  output  WIDTH  residue: operand mod 65537, in range 0..65536.
- out_id  output  IDW  index of the requester that issued this result.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  at least one pipeline stage holds valid data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - Outputs: out_valid=0, out_data=0, out_id=0, busy=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation discards in-flight results; none are emitted afterwards.
- Pipeline:
  - Stage 1 registers the selected operand and its ID.
  - Stage 2 registers the `modulo` output for the stage-1 operand, together with the stage-1 ID.
  - out_* are driven directly from stage 2.
- Advance rules (combinational):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - accept = !s1_valid || s2_adv.
- Grant: scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NREQ. The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = accept.
  - All other req_ready bits are 0.
  - No valid request means req_ready = 0.
  - req_ready must not depend on any req_valid other than the winner's priority-scan inputs. No combinational path from out_ready to req_ready other than through accept.
- On an accept with a winner:
  - s1 <= {req_data[winner], winner}, s1_valid <= 1.
  - rr_ptr <= (winner+1) mod NREQ.
  - Otherwise rr_ptr holds.
- On accept without a winner: s1_valid <= 0 only if s1 advanced or was empty.
- Stage 2 update:
  - On s1_adv: s2 <= {mod(s1_data), s1_id}, s2_valid <= 1.
  - Else, if out_ready && s2_valid: s2_valid <= 0.
- Latency:
  - Operand accepted at edge k gives out_valid=1 after edge k+1.
  - This is two registered stages, with one cycle from accept to s1 and one from s1 to s2.
  - Throughput is 1 result/cycle with out_ready held high.
- Stall behaviour:
  - out_valid=1 with out_ready=0 freezes both stages; out_data and out_id stay stable.
  - Once both stages are full, accept=0 and all req_ready are 0.
  - No result is ever dropped or duplicated.
- Arithmetic:
  - Residue r satisfies 0 ≤ r ≤ 65536 and r ≡ operand (mod 65537).
  - For negative operands, add multiples of 65537 until non-negative.
  - Upper WIDTH-17 bits of out_data are always 0.
- Simultaneous events: a new accept, a stage-1 to stage-2 advance and an output drain in the same cycle are all legal together.
- busy = s1_valid || s2_valid.
- Ordering: results are emitted in acceptance order.

Test Plan:
- Reset then single request: req_valid=0001, req_data[0]=65540, out_ready=1.
  - Expect req_ready=0001 for one cycle.
  - Then out_valid=1, out_data=3, out_id=0 two edges later; busy falls after the drain.
- Residue sweep on requester 2: issue 0, 65537, -1, -48577, 123085 back-to-back.
  - Expect out_data 0, 0, 65536, 16960, 57548 in order, on consecutive cycles, all with out_id=2.
- Fairness: all four req_valid held high, out_ready=1.
  - Expect grant order 0,1,2,3,0,1,… and out_id in the same sequence, with one grant per cycle.
- Backpressure: continuous requests on 1 and 3, out_ready=0 for 5 cycles.
  - Expect out_valid stable with the same data and ID throughout, and exactly 2 accepts total before the stall.
  - Release out_ready: the pipeline drains in order and the grants resume alternating.
- Reset mid-flight: two operands in flight, rst=1 for one edge.
  - Expect out_valid=0, busy=0 and req_ready=0 during reset.
  - The next accepted request is chosen from index 0, and the in-flight results never appear.
- Sparse requests: req_valid pulses on requester 3 only, every third cycle.
  - Expect each result 2 edges after its accept, and rr_ptr wraps to 0 after each grant.
